cpu_controller: RTL and testbench

- Fetch/decode/sequence unit that sits directly upstream of the 16-bit datapath and drives every one of its control inputs.
- Owns the program counter, the instruction register and the memory command interface.
- Executes one instruction as a fixed multi-cycle state sequence: fetch, decode, execute, PC update.
- Shares a single-port, one-cycle-latency synchronous RAM between instruction fetch and LDR/STR.

---
 rtl/cpu_controller.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_cpu_controller.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Fetch / decode / sequence unit for the 16-bit datapath. Owns the program
// counter, the instruction register and the address register used by LDR/STR,
// and drives every datapath control input as a Moore function of the state
// and the instruction register.
//
// A single-port RAM with one-cycle read latency is shared between instruction
// fetch and LDR/STR.
//
// Optional feature (compile-time macro CTRL_ILLEGAL_TRAP_EN):
//   defined   : an undefined {op,sub} encoding enters HALT (halted=1)
//   undefined : an undefined encoding behaves as a NOP (PC<=PC+1, refetch)
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mdata           RAM read data, valid one cycle after a read command
//   Z_out           datapath status flags {N, V, Z}
//   r7topc          low 9 bits of R7, target for BX
//   datapath_out    low PC_W bits of the datapath result, captured as the
//                   LDR/STR effective address
//   mem_addr        RAM address
//   mem_cmd         RAM command: 00 idle, 01 read, 10 write
//   vsel            write-back source: 0 mdata, 1 sximm8, 2 PC+1, 3 datapath
//   writenum/readnum register file write / read indices
//   write, loada, loadb, loadc, loads, asel, bsel
//                   datapath strobes and operand selects
//   shift, ALUop    shifter and ALU operation
//   sximm8, sximm5  IR[7:0] and IR[4:0] sign-extended to 16 bits
//   PC              address of the current instruction
//   halted          high while in the HALT state
// -----------------------------------------------------------------------------
module cpu_controller #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     mdata,
  input  logic [2:0]      Z_out,
  input  logic [8:0]      r7topc,
  input  logic [PC_W-1:0] datapath_out,
  output logic [PC_W-1:0] mem_addr,
  output logic [1:0]      mem_cmd,
  output logic [1:0]      vsel,
  output logic [2:0]      writenum,
  output logic [2:0]      readnum,
  output logic            write,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            loads,
  output logic            asel,
  output logic            bsel,
  output logic [1:0]      shift,
  output logic [1:0]      ALUop,
  output logic [15:0]     sximm8,
  output logic [15:0]     sximm5,
  output logic [PC_W-1:0] PC,
  output logic            halted
);

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [4:0] S_RESET   = 5'd0;
  localparam logic [4:0] S_IF1     = 5'd1;
  localparam logic [4:0] S_IF2     = 5'd2;
  localparam logic [4:0] S_DECODE  = 5'd3;
  localparam logic [4:0] S_WR_IMM  = 5'd4;
  localparam logic [4:0] S_GET_A   = 5'd5;
  localparam logic [4:0] S_GET_B   = 5'd6;
  localparam logic [4:0] S_ALU     = 5'd7;
  localparam logic [4:0] S_WB      = 5'd8;
  localparam logic [4:0] S_ADDR    = 5'd9;
  localparam logic [4:0] S_LD_ADDR = 5'd10;
  localparam logic [4:0] S_RD1     = 5'd11;
  localparam logic [4:0] S_RD2     = 5'd12;
  localparam logic [4:0] S_PASS    = 5'd13;
  localparam logic [4:0] S_WR      = 5'd14;
  localparam logic [4:0] S_BR      = 5'd15;
  localparam logic [4:0] S_BL      = 5'd16;
  localparam logic [4:0] S_BX      = 5'd17;
  localparam logic [4:0] S_HALT    = 5'd18;

  logic [4:0]      state, state_nxt;
  logic [15:0]     ir;
  logic [PC_W-1:0] addr_reg;
  logic [PC_W-1:0] pc_nxt, pc_inc, pc_br;

  // Instruction fields
  logic [2:0] op, rn, rd, rm;
  logic [1:0] sub, sh;

  assign op  = ir[15:13];
  assign sub = ir[12:11];
  assign rn  = ir[10:8];
  assign rd  = ir[7:5];
  assign sh  = ir[4:3];
  assign rm  = ir[2:0];

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // Instruction class decode
  logic is_movi, is_movr, is_alu, is_cmp, is_mvn, is_ldr, is_str;
  logic is_b, is_bl, is_bx, is_halt, is_illegal;

  assign is_movi    = ({op, sub} == 5'b110_10);
  assign is_movr    = ({op, sub} == 5'b110_00);
  assign is_alu     = (op == 3'b101);
  assign is_cmp     = is_alu && (sub == 2'b01);
  assign is_mvn     = is_alu && (sub == 2'b11);
  assign is_ldr     = ({op, sub} == 5'b011_00);
  assign is_str     = ({op, sub} == 5'b100_00);
  assign is_b       = ({op, sub} == 5'b001_00);
  assign is_bl      = ({op, sub} == 5'b010_11);
  assign is_bx      = ({op, sub} == 5'b010_00);
  assign is_halt    = ({op, sub} == 5'b111_00);
  assign is_illegal = !(is_movi || is_movr || is_alu || is_ldr || is_str ||
                        is_b || is_bl || is_bx || is_halt);

  // Branch condition on {N, V, Z}; codes 101..111 are never taken.
  logic flag_n, flag_v, flag_z, br_taken;

  assign flag_n = Z_out[2];
  assign flag_v = Z_out[1];
  assign flag_z = Z_out[0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can leave it unassigned and infer a latch.
    br_taken = 1'b0;
    case (rn)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = flag_z;
      3'b010:  br_taken = !flag_z;
      3'b011:  br_taken = (flag_n != flag_v);
      3'b100:  br_taken = (flag_n != flag_v) || flag_z;
      default: br_taken = 1'b0;
    endcase
  end

  // PC arithmetic wraps modulo 2^PC_W; the branch offset is truncated to PC_W.
  assign pc_inc = PC + PC_W'(1);
  assign pc_br  = pc_inc + sximm8[PC_W-1:0];

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_IF1;
      S_IF1:    state_nxt = S_IF2;
      S_IF2:    state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_movi)                         state_nxt = S_WR_IMM;
        else if (is_movr)                    state_nxt = S_GET_B;
        else if (is_alu || is_ldr || is_str) state_nxt = S_GET_A;
        else if (is_b)                       state_nxt = S_BR;
        else if (is_bl)                      state_nxt = S_BL;
        else if (is_bx)                      state_nxt = S_BX;
        else if (is_halt)                    state_nxt = S_HALT;
        else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_nxt = S_HALT;
`else
          state_nxt = S_IF1;
`endif
        end
      end
      S_GET_A:   state_nxt = (is_ldr || is_str) ? S_ADDR : S_GET_B;
      S_GET_B:   state_nxt = is_str ? S_PASS : S_ALU;
      S_ALU:     state_nxt = is_cmp ? S_IF1 : S_WB;
      S_ADDR:    state_nxt = S_LD_ADDR;
      S_LD_ADDR: state_nxt = is_ldr ? S_RD1 : S_GET_B;
      S_RD1:     state_nxt = S_RD2;
      S_PASS:    state_nxt = S_WR;
      S_WR_IMM, S_WB, S_RD2, S_WR, S_BR, S_BL, S_BX: state_nxt = S_IF1;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_RESET;
    endcase
  end

  // PC update happens in the last execute state of each instruction.
  always_comb begin
    pc_nxt = PC;
    case (state)
      S_WR_IMM, S_WB, S_RD2, S_WR: pc_nxt = pc_inc;
      S_ALU:    if (is_cmp) pc_nxt = pc_inc;
      S_BR:     pc_nxt = br_taken ? pc_br : pc_inc;
      S_BL:     pc_nxt = pc_br;
      S_BX:     pc_nxt = PC_W'(r7topc);
`ifndef CTRL_ILLEGAL_TRAP_EN
      S_DECODE: if (is_illegal) pc_nxt = pc_inc;
`endif
      default:  pc_nxt = PC;
    endcase
  end

  // NOTE: all state here is sequential and assigned with non-blocking (<=) so
  // every register samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      PC       <= RESET_PC;
      ir       <= '0;
      addr_reg <= '0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      if (state == S_IF2)     ir       <= mdata;
      if (state == S_LD_ADDR) addr_reg <= datapath_out;
    end
  end

  // Moore outputs: decoded from state and IR only.
  always_comb begin
    mem_addr = '0;
    mem_cmd  = MEM_IDLE;
    vsel     = 2'd0;
    writenum = 3'd0;
    readnum  = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    halted   = 1'b0;
    case (state)
      S_IF1, S_IF2: begin
        mem_addr = PC;
        mem_cmd  = MEM_READ;
      end
      S_WR_IMM: begin
        vsel     = 2'd1;
        writenum = rn;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        // STR routes the store data register through the B operand.
        readnum = is_str ? rd : rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        // MOV and MVN ignore the A operand, so force it to zero.
        asel  = is_movr || is_mvn;
        ALUop = is_movr ? 2'b00 : sub;
        shift = sh;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      S_WB: begin
        vsel     = 2'd3;
        writenum = rd;
        write    = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_RD1: begin
        mem_addr = addr_reg;
        mem_cmd  = MEM_READ;
      end
      S_RD2: begin
        mem_addr = addr_reg;
        mem_cmd  = MEM_READ;
        vsel     = 2'd0;
        writenum = rd;
        write    = 1'b1;
      end
      S_PASS: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_WR: begin
        mem_addr = addr_reg;
        mem_cmd  = MEM_WRITE;
      end
      S_BL: begin
        vsel     = 2'd2;
        writenum = 3'd7;
        write    = 1'b1;
      end
      S_BX:   readnum = rd;
      S_HALT: halted  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//
// Scoreboarded bench for cpu_controller. A stimulus process places each
// instruction in a behavioural RAM at the model PC and pushes the expected
// per-cycle control word sequence for that instruction; a monitor process pops
// one expected word per clock and compares it with the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

  localparam int PC_W = 9;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     mdata;
  logic [2:0]      z_out;
  logic [8:0]      r7topc;
  logic [PC_W-1:0] datapath_out;
  logic [PC_W-1:0] mem_addr;
  logic [1:0]      mem_cmd;
  logic [1:0]      vsel;
  logic [2:0]      writenum, readnum;
  logic            write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]      shift, alu_op;
  logic [15:0]     sximm8, sximm5;
  logic [PC_W-1:0] pc;
  logic            halted;

  cpu_controller #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
    .clk(clk), .rst_n(rst_n), .mdata(mdata), .Z_out(z_out), .r7topc(r7topc),
    .datapath_out(datapath_out), .mem_addr(mem_addr), .mem_cmd(mem_cmd),
    .vsel(vsel), .writenum(writenum), .readnum(readnum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
    .bsel(bsel), .shift(shift), .ALUop(alu_op), .sximm8(sximm8),
    .sximm5(sximm5), .PC(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency. Writes are ignored:
  // every fetched word is placed by the stimulus process just before fetch.
  logic [15:0] ram [0:511];
  always @(posedge clk) if (mem_cmd == 2'b01) mdata <= ram[mem_addr];

  typedef struct packed {
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [1:0]  vsel;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [8:0]  pc;
    logic        halted;
  } ctrl_t;

  typedef struct {
    ctrl_t v;
    ctrl_t m;
    string tag;
  } exp_t;

  typedef enum {K_MOVI, K_MOVR, K_ALU, K_LDR, K_STR, K_B, K_BL, K_BX, K_ILL, K_HALT} kind_e;

  exp_t sb_q[$];
  int   n_vec   = 0;
  int   n_miss  = 0;
  bit   running = 1'b0;
  int   model_pc;

  function automatic ctrl_t sample();
    ctrl_t s;
    s = '{mem_cmd: mem_cmd, mem_addr: mem_addr, vsel: vsel, writenum: writenum,
          readnum: readnum, write: write, loada: loada, loadb: loadb,
          loadc: loadc, loads: loads, asel: asel, bsel: bsel, shift: shift,
          alu_op: alu_op, sximm8: sximm8, sximm5: sximm5, pc: pc,
          halted: halted};
    return s;
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Fields that carry meaning in a given cycle are compared; selects and
  // indices are only compared when the strobe that consumes them is active.
  function automatic void push(input ctrl_t c, input bit rd_care, input bit imm_care,
                               input string tag);
    exp_t e;
    e.v = c;
    e.m = '0;
    e.m.mem_cmd = '1; e.m.write = 1; e.m.loada = 1; e.m.loadb = 1;
    e.m.loadc = 1; e.m.loads = 1; e.m.pc = '1; e.m.halted = 1;
    if (c.mem_cmd != 2'b00) e.m.mem_addr = '1;
    if (c.write) begin e.m.vsel = '1; e.m.writenum = '1; end
    if (c.loada || c.loadb || rd_care) e.m.readnum = '1;
    if (c.loadc || c.loads) begin
      e.m.asel = 1; e.m.bsel = 1; e.m.shift = '1; e.m.alu_op = '1;
    end
    if (imm_care) begin e.m.sximm8 = '1; e.m.sximm5 = '1; end
    e.tag = tag;
    sb_q.push_back(e);
  endfunction

  function automatic kind_e kind_of(input logic [15:0] ir);
    casez (ir[15:11])
      5'b110_10: return K_MOVI;
      5'b110_00: return K_MOVR;
      5'b101_??: return K_ALU;
      5'b011_00: return K_LDR;
      5'b100_00: return K_STR;
      5'b001_00: return K_B;
      5'b010_11: return K_BL;
      5'b010_00: return K_BX;
      5'b111_00: return K_HALT;
      default:   return K_ILL;
    endcase
  endfunction

  // Reference model: expected control words for one instruction at pc.
  task automatic model(input logic [15:0] ir, input logic [2:0] z, input logic [8:0] r7,
                       input logic [8:0] dp, input int pc, input int halt_n,
                       output int next_pc);
    ctrl_t b, c;
    kind_e k;
    int s8, s5;
    logic [2:0] rn, rd, rm;
    logic [1:0] sub, sh;
    bit taken, n_f, v_f, z_f;
    bit halts;
    k   = kind_of(ir);
    rn  = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
    sub = ir[12:11]; sh = ir[4:3];
    s8  = ir[7] ? int'(ir[7:0]) - 256 : int'(ir[7:0]);
    s5  = ir[4] ? int'(ir[4:0]) - 32  : int'(ir[4:0]);
    n_f = z[2]; v_f = z[1]; z_f = z[0];

    b = '0;
    b.pc = 9'(pc);
    c = b; c.mem_cmd = 2'b01; c.mem_addr = 9'(pc);
    push(c, 0, 0, "IF1");
    push(c, 0, 0, "IF2");
    b.sximm8 = 16'(s8);
    b.sximm5 = 16'(s5);
    push(b, 0, 1, "DECODE");

    next_pc = (pc + 1) & 511;
    halts   = 0;
    case (k)
      K_MOVI: begin
        c = b; c.vsel = 2'd1; c.writenum = rn; c.write = 1;
        push(c, 0, 1, "WR_IMM");
      end
      K_MOVR: begin
        c = b; c.readnum = rm; c.loadb = 1; push(c, 0, 1, "GET_B");
        c = b; c.asel = 1; c.shift = sh; c.loadc = 1; push(c, 0, 1, "ALU");
        c = b; c.vsel = 2'd3; c.writenum = rd; c.write = 1; push(c, 0, 1, "WB");
      end
      K_ALU: begin
        c = b; c.readnum = rn; c.loada = 1; push(c, 0, 1, "GET_A");
        c = b; c.readnum = rm; c.loadb = 1; push(c, 0, 1, "GET_B");
        c = b; c.asel = (sub == 2'b11); c.alu_op = sub; c.shift = sh;
        if (sub == 2'b01) c.loads = 1; else c.loadc = 1;
        push(c, 0, 1, "ALU");
        if (sub != 2'b01) begin
          c = b; c.vsel = 2'd3; c.writenum = rd; c.write = 1; push(c, 0, 1, "WB");
        end
      end
      K_LDR, K_STR: begin
        c = b; c.readnum = rn; c.loada = 1; push(c, 0, 1, "GET_A");
        c = b; c.bsel = 1; c.loadc = 1; push(c, 0, 1, "ADDR");
        push(b, 0, 1, "LD_ADDR");
        if (k == K_LDR) begin
          c = b; c.mem_cmd = 2'b01; c.mem_addr = dp; push(c, 0, 1, "RD1");
          c.vsel = 2'd0; c.writenum = rd; c.write = 1; push(c, 0, 1, "RD2");
        end else begin
          c = b; c.readnum = rd; c.loadb = 1; push(c, 0, 1, "GET_B_STR");
          c = b; c.asel = 1; c.loadc = 1; push(c, 0, 1, "PASS");
          c = b; c.mem_cmd = 2'b10; c.mem_addr = dp; push(c, 0, 1, "WR");
        end
      end
      K_B: begin
        case (rn)
          3'd0:    taken = 1;
          3'd1:    taken = z_f;
          3'd2:    taken = !z_f;
          3'd3:    taken = (n_f != v_f);
          3'd4:    taken = (n_f != v_f) || z_f;
          default: taken = 0;
        endcase
        push(b, 0, 1, "BR");
        if (taken) next_pc = (pc + 1 + s8) & 511;
      end
      K_BL: begin
        c = b; c.vsel = 2'd2; c.writenum = 3'd7; c.write = 1; push(c, 0, 1, "BL");
        next_pc = (pc + 1 + s8) & 511;
      end
      K_BX: begin
        c = b; c.readnum = rd; push(c, 1, 1, "BX");
        next_pc = int'(r7);
      end
      K_HALT: halts = 1;
      default: halts = TRAP;
    endcase

    if (halts) begin
      c = b; c.halted = 1;
      for (int i = 0; i < halt_n; i++) push(c, 0, 1, "HALT");
      next_pc = pc;
    end
  endtask

  // Called one step after the rising edge that puts the DUT into IF1.
  task automatic run_instr(input logic [15:0] ir, input logic [2:0] z, input logic [8:0] r7,
                           input logic [8:0] dp, input int halt_n);
    int nxt, n;
    ram[model_pc] = ir;
    z_out = z; r7topc = r7; datapath_out = dp;
    model(ir, z, r7, dp, model_pc, halt_n, nxt);
    n = sb_q.size();
    repeat (n) begin @(posedge clk); #1; end
    model_pc = nxt;
  endtask

  task automatic run_random();
    logic [15:0] ir;
    int k;
    ir = 16'($urandom);
    k  = $urandom_range(0, TRAP ? 7 : 8);
    case (k)
      0: ir[15:11] = 5'b110_10;
      1: ir[15:11] = 5'b110_00;
      2: ir[15:13] = 3'b101;
      3: ir[15:11] = 5'b011_00;
      4: ir[15:11] = 5'b100_00;
      5: ir[15:11] = 5'b001_00;
      6: ir[15:11] = 5'b010_11;
      7: ir[15:11] = 5'b010_00;
      default: while (kind_of(ir) != K_ILL) ir = 16'($urandom);
    endcase
    run_instr(ir, 3'($urandom), 9'($urandom), 9'($urandom), 0);
  endtask

  // Monitor: one expected word per cycle while a program is running.
  initial begin
    exp_t  e;
    ctrl_t a;
    forever begin
      @(negedge clk);
      if (running) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL scoreboard_underflow: DUT cycle with no expected word at pc %h", pc);
        end else begin
          e = sb_q.pop_front();
          a = sample();
          n_vec++;
          if ((a & e.m) !== (e.v & e.m)) begin
            n_miss++;
            $display("FAIL %s @pc %h: got %h, expected %h (mask %h)",
                     e.tag, e.v.pc, a & e.m, e.v & e.m, e.m);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; z_out = '0; r7topc = '0; datapath_out = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 80'(sample()), 80'd0);
    check("reset_pc", 80'(pc), 80'd0);

    rst_n = 1'b1;
    @(posedge clk); #1;
    running  = 1'b1;
    model_pc = 0;

    // Directed program
    run_instr(16'hD205, 3'b000, 9'h000, 9'h000, 0); // MOV R2,#5
    run_instr(16'hA162, 3'b000, 9'h000, 9'h000, 0); // ADD R3,R1,R2
    run_instr(16'h6283, 3'b000, 9'h000, 9'h008, 0); // LDR R4,[R2,#3]
    run_instr(16'hD000, 3'b000, 9'h000, 9'h000, 0); // MOV R0,#0
    run_instr(16'hD105, 3'b000, 9'h000, 9'h000, 0); // MOV R1,#5
    run_instr(16'h21FE, 3'b001, 9'h000, 9'h000, 0); // BEQ -2 taken -> 4
    run_instr(16'hD105, 3'b000, 9'h000, 9'h000, 0);
    run_instr(16'h21FE, 3'b000, 9'h000, 9'h000, 0); // BEQ -2 not taken -> 6
    run_instr(16'hA902, 3'b000, 9'h000, 9'h000, 0); // CMP R1,R2
    run_instr(16'h8161, 3'b000, 9'h000, 9'h014, 0); // STR R3,[R1,#1]
    run_instr(16'hB8A2, 3'b000, 9'h000, 9'h000, 0); // MVN R5,R2
    run_instr(16'h5F03, 3'b000, 9'h000, 9'h000, 0); // BL +3 -> 13
    run_instr(16'h40E0, 3'b000, 9'h1FE, 9'h000, 0); // BX R7 -> 0x1FE
    run_instr(16'hD3FF, 3'b000, 9'h000, 9'h000, 0); // MOV R3,#-1
    run_instr(16'hD37F, 3'b000, 9'h000, 9'h000, 0); // PC 0x1FF wraps to 0
    run_instr(16'hC0CB, 3'b000, 9'h000, 9'h000, 0); // MOV R6,R3 with shift
    run_instr(16'h20FB, 3'b000, 9'h000, 9'h000, 0); // B -5 wraps to 0x1FD

    for (int i = 0; i < 400; i++) run_random();

    run_instr(16'hE000, 3'b000, 9'h000, 9'h000, 20); // HALT, held 20 cycles
    running = 1'b0;
    check("halt_held", 80'(halted), 80'd1);

    // Reset asserted in the middle of a STR write cycle
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    running  = 1'b1;
    model_pc = 0;
    begin
      int nxt;
      ram[0] = 16'h8161;
      datapath_out = 9'h0AB;
      model(16'h8161, 3'b000, 9'h000, 9'h0AB, 0, 0, nxt);
      repeat (8) begin @(posedge clk); #1; end
      @(negedge clk); #1;
      running = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("rst_in_wr_mem_cmd", 80'(mem_cmd), 80'd0);
      check("rst_in_wr_pc", 80'(pc), 80'd0);
      check("rst_in_wr_ctrl", 80'(sample()), 80'd0);
      check("rst_in_wr_drained", 80'(sb_q.size()), 80'd0);
    end

    // Undefined encoding: trap to HALT or behave as NOP
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    running  = 1'b1;
    model_pc = 0;
    run_instr(16'hE800, 3'b000, 9'h000, 9'h000, 5);
    if (!TRAP) run_instr(16'hD201, 3'b000, 9'h000, 9'h000, 0);
    running = 1'b0;
    check("final_drain", 80'(sb_q.size()), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
